// File: rtl/serial_subtractor_pkg.sv
// Purpose : shared types and helpers for the bit-serial subtractor.
// Latency : n/a (package only).
// Backpressure: n/a; start is ignored while busy, there is no stall input.
package serial_subtractor_pkg;

    // Control FSM encoding.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Bit-counter width for a given operand width (counts 0..width-1).
    function automatic int calc_cnt_w(input int width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/serial_subtractor_fs.sv
// Purpose : single-bit full subtractor cell, x - y - bin.
// Latency : combinational, zero cycles.
// Backpressure: none.
// Ports   : x, y, bin in; d (difference bit), bout (borrow out) out.
module serial_subtractor_fs (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = x ^ y ^ bin;
    // Borrow when y exceeds x, or when x==y and a borrow comes in.
    assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Purpose : bit-serial unsigned subtractor, diff = a - b, LSB first, one full-subtractor cell.
// Latency : done pulses WIDTH cycles after the accepting edge; one result per WIDTH+1 cycles.
// Backpressure: start is accepted only while busy=0 (IDLE or DONE); starts during RUN are dropped.
// Ports   : clk, rst_n (async active-low); start/a/b request; busy, done, diff, borrow results.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
);

    localparam int CNT_W = calc_cnt_w(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_e           state_q,  state_d;
    logic [WIDTH-1:0] sa_q,     sa_d;
    logic [WIDTH-1:0] sb_q,     sb_d;
    logic [WIDTH-1:0] diff_q,   diff_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic             bor_q,    bor_d;     // running borrow between bit slices
    logic             borrow_q, borrow_d;  // published final borrow
    logic             busy_q,   busy_d;
    logic             done_q,   done_d;

    logic fs_d;
    logic fs_bout;

    serial_subtractor_fs u_fs (
        .x    (sa_q[0]),
        .y    (sb_q[0]),
        .bin  (bor_q),
        .d    (fs_d),
        .bout (fs_bout)
    );

    always_comb begin
        state_d  = state_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        diff_d   = diff_q;
        cnt_d    = cnt_q;
        bor_d    = bor_q;
        borrow_d = borrow_q;
        busy_d   = busy_q;
        done_d   = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    sa_d    = a;
                    sb_d    = b;
                    bor_d   = 1'b0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                // Difference bits enter at the MSB; after WIDTH shifts bit 0 lands at diff[0].
                diff_d = {fs_d, diff_q[WIDTH-1:1]};
                bor_d  = fs_bout;
                sa_d   = sa_q >> 1;
                sb_d   = sb_q >> 1;
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d  = ST_DONE;
                    busy_d   = 1'b0;
                    done_d   = 1'b1;
                    borrow_d = fs_bout;
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            sa_q     <= '0;
            sb_q     <= '0;
            diff_q   <= '0;
            cnt_q    <= '0;
            bor_q    <= 1'b0;
            borrow_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            diff_q   <= diff_d;
            cnt_q    <= cnt_d;
            bor_q    <= bor_d;
            borrow_q <= borrow_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign diff   = diff_q;
    assign borrow = borrow_q;

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
Bit-serial unsigned subtractor that computes diff = a - b over WIDTH clock cycles, LSB first. It uses a single full-subtractor cell and a registered borrow. It is the inverse-operation counterpart to the team's adder cells. It sits beside them in the arithmetic library as an area-minimal multi-cycle datapath block driven by a start/done handshake.

Parameters:
WIDTH, 8, operand and result width in bits (legal range 2..32).

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled on rising clk; accepted only while busy=0
a  input  WIDTH  minuend; sampled on the accepting edge only
b  input  WIDTH  subtrahend; sampled on the accepting edge only
busy  output  1  high while a subtraction is in progress
done  output  1  single-cycle pulse; diff/borrow valid
diff  output  WIDTH  (a - b) mod 2^WIDTH
borrow  output  1  final borrow out; 1 iff a < b (unsigned)

Behaviour:
- Reset (rst_n=0, asynchronous, any state): state=IDLE, busy=0, done=0, diff=0, borrow=0, bit counter=0, operand shift registers=0.
- Reset is released synchronously to clk by the environment. The first active edge after release sees IDLE.
- States:
  - IDLE: wait for start.
  - RUN: one bit per cycle.
  - DONE: one cycle, done=1.
- IDLE, start=1 at edge E0:
  - capture a into shift reg SA and b into SB;
  - clear borrow reg and counter;
  - go to RUN; busy=1 from E0.
- RUN, each edge (WIDTH edges, E1..EWIDTH):
  - feed SA[0], SB[0], borrow reg into the full_subtractor cell;
  - shift difference bit into diff from the MSB side (after WIDTH shifts, bit 0 sits at diff[0]);
  - update borrow reg with bout;
  - shift SA and SB right by 1;
  - increment counter.
- On edge EWIDTH (counter reaches WIDTH-1 before the edge): go to DONE. done=1 and busy=0 from EWIDTH. borrow output = final bout.
- Latency: done is high in the cycle after edge E0+WIDTH, i.e. WIDTH edges after acceptance.
- DONE lasts exactly one cycle, then IDLE, unless start is accepted.
- diff and borrow hold their values until the next accepted start. During RUN, diff is partial and not valid; borrow output holds its previous result until DONE.
- start while busy=1: ignored; operands are not resampled; no error flag.
- start in the DONE cycle: accepted (busy=0). That edge returns to RUN with new operands. done drops; diff/borrow keep the previous result until the new DONE. Throughput is one result per WIDTH+1 cycles.
- start held high continuously: back-to-back operations, each re-sampling a/b at its accepting edge.
- rst_n asserted mid-RUN: immediate abort to the reset values. No done is produced for the aborted operation.
- Arithmetic: per-bit cell is d = x ^ y ^ bin, bout = (~x & y) | (~(x ^ y) & bin). No signed interpretation; signed callers use diff directly (two's complement) and ignore borrow.

Decomposition:
- Shared package: state encoding constants (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and a counter-width constant CNT_W = clog2(WIDTH).
- One natural sub-module: full_subtractor. Purely combinational, ports x, y, bin, d, bout. It is instantiated once; the serial block owns all registers.

Test Plan:
- WIDTH=8, a=0x05, b=0x03, start pulse -> busy 8 cycles; done 1 cycle at edge 8; diff=0x02, borrow=0.
- a=0x03, b=0x05 -> diff=0xFE, borrow=1. a=0x00, b=0xFF -> diff=0x01, borrow=1. a=b=0xA5 -> diff=0x00, borrow=0.
- Operands 0x40/0x10 accepted, then start with a=0xFF, b=0x00 pulsed at cycle 3 of RUN -> ignored; result diff=0x30, borrow=0 at the original done time.
- start held high with (0x10,0x01) then (0x01,0x02) presented at the DONE edge -> first done diff=0x0F/borrow=0, second done 9 cycles later diff=0xFF/borrow=1; no idle gap.
- rst_n pulsed low mid-RUN (cycle 4) between clock edges -> busy/done/diff/borrow go to 0 immediately, no done pulse. Next start (0x09,0x04) gives diff=0x05 normally.
- Exhaustive sweep at WIDTH=4 (all 256 a/b pairs) -> diff and borrow match a-b against the reference model on every done pulse.
